// File: rtl/jups_bcd_pkg.sv
// Shared constants and types for the sequential BCD-to-binary converter.
package jups_bcd_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  localparam int BCD_DIGITS = 3;
  localparam int FULL_W     = 10;
  localparam int STEPS      = 10;
  localparam int DIGIT_MAX  = 9;
  localparam int WORK_W     = 4 * BCD_DIGITS + FULL_W;
  localparam int CNT_W      = 4;

  function automatic logic digit_bad(input logic [3:0] digit);
    return digit > 4'(DIGIT_MAX);
  endfunction

endpackage

// File: rtl/bcd_to_bin_seq_if.sv
// Start/busy/done bundle between a digit source and the BCD-to-binary converter.
interface bcd_to_bin_seq_if #(
  parameter int BIN_W = 9
) ();
  // start is taken only while busy=0; once taken the digits are captured and may
  // change freely. done pulses for one cycle and bin/ovf/err hold until the next done.
  logic             start;
  logic [3:0]       bcd1;
  logic [3:0]       bcd2;
  logic [3:0]       bcd3;
  logic             busy;
  logic             done;
  logic [BIN_W-1:0] bin;
  logic             ovf;
  logic             err;

  modport master (
    output start, bcd1, bcd2, bcd3,
    input  busy, done, bin, ovf, err
  );

  modport slave (
    input  start, bcd1, bcd2, bcd3,
    output busy, done, bin, ovf, err
  );
endinterface

// File: rtl/bcd_digit_sub3.sv
// Reverse double-dabble correction for one BCD digit field after a right shift.
module bcd_digit_sub3 (
  input  logic [3:0] digit,
  output logic [3:0] fixed
);
  assign fixed = (digit >= 4'd8) ? digit - 4'd3 : digit;
endmodule

// File: rtl/bcd_to_bin_seq.sv
// Sequential 3-digit BCD to saturated binary converter (10 shift steps per result).
// Optional digit validity check enabled by defining BCD2BIN_CHECK_EN.
module bcd_to_bin_seq
  import jups_bcd_pkg::*;
#(
  parameter int BIN_W = 9
) (
  input  logic                   clk,
  input  logic                   rst,
  bcd_to_bin_seq_if.slave        bus,
  output state_t                 fsm_state
);

  localparam logic [FULL_W-1:0] MAX_FULL = FULL_W'((1 << BIN_W) - 1);

  state_t              state;
  state_t              state_next;
  logic                load;
  logic                last;
  logic [CNT_W-1:0]    count;
  logic [WORK_W-1:0]   work;
  logic [WORK_W-1:0]   shifted;
  logic [WORK_W-1:0]   stepped;
  logic [FULL_W-1:0]   full;
  logic                sat;
  logic [BIN_W-1:0]    res_bin;
  logic                done_r;
  logic [BIN_W-1:0]    bin_r;
  logic                ovf_r;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    last       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.start) begin
          load       = 1'b1;
          state_next = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (count == CNT_W'(STEPS - 1)) begin
          last       = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // One step: shift the whole word right, then correct each digit field.
  assign shifted = work >> 1;
  assign stepped[FULL_W-1:0] = shifted[FULL_W-1:0];

  for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_digit
    bcd_digit_sub3 u_sub3 (
      .digit(shifted[FULL_W + 4*g +: 4]),
      .fixed(stepped[FULL_W + 4*g +: 4])
    );
  end

  // On the last step the accumulator is taken from the stepped word, not the register.
  assign full    = stepped[FULL_W-1:0];
  assign sat     = full > MAX_FULL;
  assign res_bin = sat ? {BIN_W{1'b1}} : full[BIN_W-1:0];

`ifdef BCD2BIN_CHECK_EN
  logic bad;
  logic err_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      bad   <= 1'b0;
      err_r <= 1'b0;
    end else begin
      if (load)
        bad <= digit_bad(bus.bcd1) | digit_bad(bus.bcd2) | digit_bad(bus.bcd3);
      if (last)
        err_r <= bad;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bin_r <= '0;
      ovf_r <= 1'b0;
    end else if (last) begin
      bin_r <= bad ? '0 : res_bin;
      ovf_r <= bad ? 1'b0 : sat;
    end
  end

  assign bus.err = err_r;
`else
  always_ff @(posedge clk) begin
    if (rst) begin
      bin_r <= '0;
      ovf_r <= 1'b0;
    end else if (last) begin
      bin_r <= res_bin;
      ovf_r <= sat;
    end
  end

  assign bus.err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      work   <= '0;
      count  <= '0;
      done_r <= 1'b0;
    end else begin
      done_r <= last;
      if (load) begin
        work  <= {bus.bcd3, bus.bcd2, bus.bcd1, {FULL_W{1'b0}}};
        count <= '0;
      end else if (state == ST_SHIFT) begin
        work  <= stepped;
        count <= count + 1'b1;
      end
    end
  end

  assign bus.busy  = (state == ST_SHIFT);
  assign bus.done  = done_r;
  assign bus.bin   = bin_r;
  assign bus.ovf   = ovf_r;
  assign fsm_state = state;

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Self-checking bench for bcd_to_bin_seq; expectations follow BCD2BIN_CHECK_EN when defined.
module tb_bcd_to_bin_seq;
  import jups_bcd_pkg::*;

  localparam int BIN_W = 9;
  localparam int W     = BIN_W + 2;

  logic   clk = 1'b0;
  logic   rst = 1'b1;
  state_t fsm_state;

  always #5 clk = ~clk;

  bcd_to_bin_seq_if #(.BIN_W(BIN_W)) bus ();

  bcd_to_bin_seq #(.BIN_W(BIN_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .fsm_state(fsm_state)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] mask_q[$];
  int           cyc_q[$];

  logic [W-1:0] mon_e;
  logic [W-1:0] mon_m;
  int           mon_c;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] model(input int d3, input int d2, input int d1);
    int               v;
    logic [BIN_W-1:0] mx;
    v  = d3 * 100 + d2 * 10 + d1;
    mx = '1;
`ifdef BCD2BIN_CHECK_EN
    if (d3 > 9 || d2 > 9 || d1 > 9) return {1'b1, 1'b0, {BIN_W{1'b0}}};
`endif
    if (v > int'(mx)) return {1'b0, 1'b1, mx};
    return {2'b00, BIN_W'(v)};
  endfunction

  // Scoreboard: every done pops one expected result and its acceptance cycle.
  always @(posedge clk) begin
    #1;
    if (bus.done) begin
      if (exp_q.size() == 0) begin
        check("spurious_done", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        mon_m = mask_q.pop_front();
        mon_c = cyc_q.pop_front();
        check("result", 32'({bus.err, bus.ovf, bus.bin} & mon_m), 32'(mon_e & mon_m));
        check("latency", 32'(cyc - mon_c), 32'd10);
      end
    end
  end

  task automatic push_exp(input int d3, input int d2, input int d1, input logic [W-1:0] mask);
    exp_q.push_back(model(d3, d2, d1));
    mask_q.push_back(mask);
    cyc_q.push_back(cyc);
  endtask

  task automatic start_conv(input int d3, input int d2, input int d1,
                            input bit push, input logic [W-1:0] mask);
    @(negedge clk);
    bus.start = 1'b1;
    bus.bcd3  = 4'(d3);
    bus.bcd2  = 4'(d2);
    bus.bcd1  = 4'(d1);
    @(posedge clk);
    #1;
    if (push) push_exp(d3, d2, d1, mask);
    check("busy_accept", 32'(bus.busy), 32'd1);
    @(negedge clk);
    bus.start = 1'b0;
    bus.bcd3  = 4'($urandom_range(0, 15));
    bus.bcd2  = 4'($urandom_range(0, 15));
    bus.bcd1  = 4'($urandom_range(0, 15));
  endtask

  task automatic wait_done(input string tag);
    bit seen    = 1'b0;
    bit busy_ok = 1'b1;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) seen = 1'b1;
      else if (!bus.busy) busy_ok = 1'b0;
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    check({tag, "_busy_held"}, 32'(busy_ok), 32'd1);
    check({tag, "_busy_low"}, 32'(bus.busy), 32'd0);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_done"}, 32'(bus.done), 32'd0);
    check({tag, "_bin"}, 32'(bus.bin), 32'd0);
    check({tag, "_ovf"}, 32'(bus.ovf), 32'd0);
    check({tag, "_err"}, 32'(bus.err), 32'd0);
    check({tag, "_state"}, 32'(fsm_state), 32'(ST_IDLE));
  endtask

  logic [W-1:0] full_mask;
  logic [W-1:0] bad_mask;

  initial begin
    full_mask = '1;
`ifdef BCD2BIN_CHECK_EN
    bad_mask  = '1;
`else
    bad_mask  = {1'b1, {(W-1){1'b0}}};
`endif
    bus.start = 1'b0;
    bus.bcd1  = 4'd0;
    bus.bcd2  = 4'd0;
    bus.bcd3  = 4'd0;

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_cleared("reset");
    @(negedge clk);
    rst = 1'b0;

    start_conv(2, 5, 5, 1'b1, full_mask);
    wait_done("c255");

    // Back-to-back: each start lands on the edge right after done.
    start_conv(0, 0, 0, 1'b1, full_mask);
    wait_done("c000");
    start_conv(5, 1, 1, 1'b1, full_mask);
    wait_done("c511");
    start_conv(5, 1, 2, 1'b1, full_mask);
    wait_done("c512");
    start_conv(9, 9, 9, 1'b1, full_mask);
    wait_done("c999");

    // Reset in the middle of a conversion discards it.
    start_conv(0, 4, 2, 1'b0, full_mask);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_cleared("midrst");
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check("midrst_no_done_bin", 32'(bus.bin), 32'd0);
    start_conv(1, 2, 3, 1'b1, full_mask);
    wait_done("c123");

    // start held high with digits changed mid-conversion.
    @(negedge clk);
    bus.start = 1'b1;
    bus.bcd3  = 4'd1;
    bus.bcd2  = 4'd0;
    bus.bcd1  = 4'd0;
    @(posedge clk);
    #1;
    push_exp(1, 0, 0, full_mask);
    repeat (3) @(negedge clk);
    bus.bcd3 = 4'd3;
    bus.bcd2 = 4'd4;
    bus.bcd1 = 4'd5;
    wait_done("held1");
    @(posedge clk);
    #1;
    push_exp(3, 4, 5, full_mask);
    check("held_accept_e11", 32'(bus.busy), 32'd1);
    @(negedge clk);
    bus.start = 1'b0;
    wait_done("held2");

    start_conv(0, 10, 0, 1'b1, bad_mask);
    wait_done("badigit");

    repeat (3) @(posedge clk);
    #1;
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/bcd_to_bin_seq.md
# bcd_to_bin_seq

Sequential BCD-to-binary converter: the inverse of the combinational binary-to-BCD block. It takes three BCD digits (hundreds, tens, ones), e.g. from keypad or switch entry, and produces a saturated binary value for the datapath. Conversion uses iterative reverse double-dabble (shift right, subtract 3) over a fixed 10 cycles, with a start/busy/done handshake.

## Interface
- BIN_W, 9, width of `bin` output; legal range 4..10; saturation value is 2^BIN_W-1
- clk  in  1  system clock, rising edge
- rst  in  1  reset; one clock; reset is synchronous and active-high
- start  in  1  request conversion; sampled only in IDLE
- bcd1  in  4  ones digit; captured on the accepted start edge
- bcd2  in  4  tens digit; captured on the accepted start edge
- bcd3  in  4  hundreds digit; captured on the accepted start edge
- busy  out  1  high while converting (SHIFT state)
- done  out  1  one-cycle pulse; results valid from this cycle on
- bin  out  BIN_W  converted value, saturated; held until the next done
- ovf  out  1  value exceeded 2^BIN_W-1; held with bin
- err  out  1  a digit was >9 (only with the check enabled); held with bin

## Operation
- Internal work register: 22 bits, {bcd3, bcd2, bcd1, acc[9:0]}; acc cleared on load.
- FSM states: IDLE, SHIFT.
  - IDLE: if start=1 then load the digits, clear acc, set count=0, go to SHIFT, busy=1; else stay.
  - SHIFT, one step per clock: shift the whole 22-bit register right by 1. Then, for each of the 3 digit fields, if the field is ≥8, subtract 3. Increment count.
  - After step 10 (count reaches 9 at that edge), go to IDLE. On that same edge, load the outputs, set done=1 and clear busy.
- Result: full = acc (10 bits, exact for 0..999).
  - If full > 2^BIN_W-1: bin = all ones, ovf=1.
  - Else: bin = full[BIN_W-1:0], ovf=0.
- start in SHIFT is ignored and is not queued. Digit inputs may change freely after the accepting edge.
- Reset (any state, including mid-conversion): state=IDLE, busy=0, done=0, bin=0, ovf=0, err=0, count=0. The interrupted conversion is discarded and produces no done.

## Timing
- Edge E0: start sampled in IDLE. busy=1 from E0.
- Edges E1..E10: the 10 shift steps.
- Edge E10 (last step): bin, ovf and err are updated, done=1 and busy=0 for the cycle E10..E11.
- Latency: 10 clocks from the accepting edge to done; fixed regardless of value or error.
- done falls at E11 unless another conversion completes (impossible: minimum spacing is 11 clocks).
- start high at E11, while done is still high, is accepted; back-to-back throughput is 1 conversion per 11 clocks.
- Outputs are registered and change only on done edges or reset.

## Configuration
- BCD2BIN_CHECK_EN defined:
  - On the accepting edge, each digit is checked for a value >9; the result is stored in a sticky flag for that conversion.
  - At done, err=1, bin=0 and ovf=0 if any digit was invalid. The conversion still takes the full 10 clocks.
- BCD2BIN_CHECK_EN undefined:
  - No check logic; err is held at 0.
  - Invalid digits pass through the algorithm, and bin/ovf are whatever it yields (deterministic, unspecified).

## Structure
- Shared package jups_bcd_pkg holds:
  - state encoding constants ST_IDLE, ST_SHIFT
  - BCD_DIGITS=3, FULL_W=10, STEPS=10
  - DIGIT_MAX=9
- Sub-module bcd_digit_sub3: 4-bit combinational correction, out = in≥8 ? in-3 : in. Instantiated once per digit field.
- Count and FSM live in the top; no other hierarchy.

## Test plan
- Reset, then start with 2/5/5 (255): done at E10, bin=255, ovf=0, err=0. busy high E0..E10.
- 0/0/0 and 5/1/1 (511): bin=0, then bin=511, both ovf=0. Back-to-back starts at E11 are accepted.
- 5/1/2 (512) and 9/9/9: bin=511 (0x1FF), ovf=1 for both. With BIN_W=10, 999 gives bin=999 and ovf=0.
- Start a conversion, then assert rst at E5 for one clock: no done, all outputs 0. A fresh start of 1/2/3 afterwards gives 123.
- start held high throughout a conversion, with digits changed at E3: result reflects the digits captured at E0, and the second start is accepted only at E11.
- With BCD2BIN_CHECK_EN, bcd2=4'hA: err=1, bin=0, at E10. Without the macro, err=0 for the same stimulus.
